tty_kbd_feeder: RTL and testbench
=================================

// Module: tty_kbd_feeder
// PURPOSE
//  Host-side keyboard feeder upstream of uart_tx (data/strobe/ready) on the PDP-8/I console path.
//  Buffers host bytes in a FIFO and issues one byte at a time to the serial transmitter.
//  Adds optional inter-character pacing so the PDP-8 keyboard handler keeps up.
// PARAMETERS
//  DEPTH       16  FIFO entries; power of two, >=2
//  GAP_CYCLES  0   idle clk cycles after uart_tx returns ready before next strobe (0 = none)
//  DROP_WAIT   3   max cycles to wait for tx_ready to fall after a strobe
// PORTS
//  clk         in   1   system clock (100 MHz)
//  rst         in   1   reset; synchronous, active-low
//  flush       in   1   synchronous FIFO clear
//  host_data   in   8   byte from host
//  host_valid  in   1   host byte valid
//  host_ready  out  1   FIFO can accept (not full)
//  tx_data     out  8   byte to uart_tx .data
//  tx_strobe   out  1   one-cycle load pulse to uart_tx .strobe
//  tx_ready    in   1   uart_tx .ready (idle)
//  fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  overflow    out  1   sticky: write attempted while full; cleared by rst or flush
// BEHAVIOUR
//  Reset (rst==0 at posedge): FIFO empty, fifo_level=0, host_ready=1, tx_strobe=0, tx_data=0, overflow=0, FSM=IDLE.
//  Host write: push when host_valid && host_ready at posedge; host_ready = (level!=DEPTH), registered-level based.
//  host_valid while full: byte dropped, overflow<=1, level unchanged.
//  Pointers: log2(DEPTH)-bit, wrap modulo DEPTH; level is separate counter.
//  Simultaneous push+pop: level unchanged; allowed when full (pop frees slot same cycle? no: host_ready reflects pre-pop level).
//  FSM:
//   IDLE: if level!=0 && tx_ready -> pop head into tx_data, tx_strobe=1 for exactly one cycle, -> WAIT_DROP.
//   WAIT_DROP: tx_strobe=0; tx_ready==0 -> WAIT_RDY; after DROP_WAIT cycles w/o drop -> WAIT_RDY anyway.
//   WAIT_RDY: tx_ready==1 -> (GAP_CYCLES==0 ? IDLE : GAP), gap counter loaded with GAP_CYCLES-1.
//   GAP: count down to 0 -> IDLE.
//  Latency: byte written into empty FIFO with tx_ready=1 -> tx_strobe on 2nd posedge after write (registered).
//  tx_data holds last issued byte until next pop; stable during and after strobe.
//  flush: empties FIFO, clears overflow; an already-strobed byte is not recalled; FSM finishes current
//   WAIT_*/GAP normally. flush && host_valid same cycle: flush wins, byte dropped, overflow unaffected.
//  Reset mid-transfer: FSM to IDLE immediately; uart_tx may still be shifting; next strobe waits for tx_ready.
// CONFIGURATION
//  TTY_KBD_MARK_PARITY_EN defined: tx_data[7] forced to 1 on pop (ASR-33 mark parity, as PDP-8
//   software expects 0200-0377 keyboard codes); FIFO still stores 8 bits.
//  Undefined: tx_data is the host byte unmodified.
// STRUCTURE
//  Shared package tty_pkg: FSM state encoding (IDLE, WAIT_DROP, WAIT_RDY, GAP), byte width constant 8,
//   ASCII constants (CR=8'h0D, LF=8'h0A) used by console blocks.
//  One sub-module: tty_sync_fifo (DEPTH-param, 8-bit, push/pop/level/full/empty, flush); FSM in top.
// TESTING
//  1 Reset low 2 cycles -> host_ready=1, fifo_level=0, tx_strobe=0, overflow=0.
//  2 Write 8'h41 with tx_ready=1 -> single tx_strobe pulse, tx_data=8'h41 (8'hC1 with TTY_KBD_MARK_PARITY_EN).
//  3 Burst 16 bytes 8'h00..8'h0F, tx_ready held 0 -> level=16, host_ready=0; 17th write -> overflow=1, dropped.
//  4 Release tx_ready, model uart_tx (ready low 100 cycles after strobe) -> bytes out in order 00..0F, no
//    strobe while tx_ready=0, level returns to 0.
//  5 GAP_CYCLES=50: consecutive strobes separated by >=50 cycles after tx_ready rise.
//  6 tx_ready never drops after strobe -> WAIT_RDY after 3 cycles; flush with 5 queued -> level=0, overflow=0.

Source files
------------

// File: rtl/tty_pkg.sv
// Shared console definitions: keyboard feeder FSM states, byte width and ASCII constants.
package tty_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DROP = 2'd1,
    WAIT_RDY  = 2'd2,
    GAP       = 2'd3
  } tty_state_e;

endpackage

// File: rtl/tty_sync_fifo.sv
// Byte-wide synchronous FIFO with occupancy counter and synchronous flush.
module tty_sync_fifo
  import tty_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       wdata,
  input  logic                    pop,
  output logic [BYTE_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full/empty come from the registered level, so a pop never opens a slot for a same-cycle push.
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (do_pop && !do_push) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tty_kbd_feeder.sv
// Host keyboard feeder: FIFO-buffered bytes issued one at a time to uart_tx with optional pacing.
// Define TTY_KBD_MARK_PARITY_EN to force bit 7 of every issued byte to 1 (ASR-33 mark parity).
module tty_kbd_feeder
  import tty_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0,
  parameter int DROP_WAIT  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [BYTE_W-1:0]      host_data,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_strobe,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int DW = (DROP_WAIT > 1) ? $clog2(DROP_WAIT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tty_state_e        state, state_n;
  logic [DW-1:0]     drop_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [BYTE_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;

  function automatic logic [BYTE_W-1:0] tx_format(input logic [BYTE_W-1:0] b);
`ifdef TTY_KBD_MARK_PARITY_EN
    tx_format = {1'b1, b[BYTE_W-2:0]};
`else
    tx_format = b;
`endif
  endfunction

  tty_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (host_valid),
    .wdata (host_data),
    .pop   (issue),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign host_ready = !fifo_full;
  // A flush in the same cycle suppresses the pop so the flushed head is never issued.
  assign issue = (state == IDLE) && !fifo_empty && tx_ready && !flush;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (issue) state_n = WAIT_DROP;
      WAIT_DROP: if (!tx_ready || drop_cnt == DW'(DROP_WAIT - 1)) state_n = WAIT_RDY;
      WAIT_RDY:  if (tx_ready) state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_cnt == '0) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tx_strobe <= 1'b0;
      tx_data   <= '0;
      drop_cnt  <= '0;
      gap_cnt   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      tx_strobe <= issue;
      if (issue) tx_data <= tx_format(head);
      if (issue)                   drop_cnt <= '0;
      else if (state == WAIT_DROP) drop_cnt <= drop_cnt + DW'(1);
      if (state == WAIT_RDY && tx_ready)      gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
      if (flush)                         overflow <= 1'b0;
      else if (host_valid && fifo_full)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tty_kbd_feeder.sv
// Self-checking bench for tty_kbd_feeder: queue model of the byte stream plus directed scenarios.
module tb_tty_kbd_feeder;

  localparam int DEPTH  = 16;
  localparam int GAP_G  = 50;
  localparam int BUSY   = 100;
  localparam int BUSY_G = 20;
`ifdef TTY_KBD_MARK_PARITY_EN
  localparam logic [7:0] EXP_41 = 8'hC1;
`else
  localparam logic [7:0] EXP_41 = 8'h41;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, flush = 1'b0, host_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0] host_data = 8'h00;
  logic       host_ready, tx_strobe, overflow;
  logic [7:0] tx_data;
  logic [4:0] fifo_level;

  logic       g_valid = 1'b0, g_flush = 1'b0, g_rdy = 1'b1;
  logic [7:0] g_data = 8'h00;
  logic       g_hr, g_stb, g_ovf;
  logic [7:0] g_txd;
  logic [4:0] g_lvl;

  tty_kbd_feeder u_dut (
    .clk(clk), .rst(rst), .flush(flush), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  tty_kbd_feeder #(.GAP_CYCLES(GAP_G)) u_gap (
    .clk(clk), .rst(rst), .flush(g_flush), .host_data(g_data), .host_valid(g_valid),
    .host_ready(g_hr), .tx_data(g_txd), .tx_strobe(g_stb), .tx_ready(g_rdy),
    .fifo_level(g_lvl), .overflow(g_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] fmt(input logic [7:0] b);
`ifdef TTY_KBD_MARK_PARITY_EN
    return b | 8'h80;
`else
    return b;
`endif
  endfunction

  // uart_tx stand-ins: ready drops for a fixed time after a sampled strobe
  int   ucnt = 0;
  logic man = 1'b0, man_rdy = 1'b1;
  always @(posedge clk) begin
    logic st;
    st = tx_strobe;
    #1;
    if (st) ucnt = BUSY;
    else if (ucnt > 0) ucnt--;
    tx_ready = man ? man_rdy : (ucnt == 0);
  end

  int   ugc = 0;
  int   rise_cyc = 0;
  logic have_rise = 1'b0;
  logic [7:0] g_rx[$];
  always @(posedge clk) begin
    logic st, was;
    st  = g_stb;
    was = g_rdy;
    #1;
    if (st) ugc = BUSY_G;
    else if (ugc > 0) ugc--;
    g_rdy = (ugc == 0);
    if (!was && g_rdy) begin
      rise_cyc  = cyc;
      have_rise = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0 && rst && g_stb) begin
      g_rx.push_back(g_txd);
      if (have_rise) begin
        chk("gap_len", (cyc - rise_cyc - 1 >= GAP_G), 1);
        have_rise = 1'b0;
      end
    end
  end

  // Inputs as seen at the last active edge
  logic       s_rst = 1'b0, s_flush = 1'b0, s_valid = 1'b0, s_rdy = 1'b0, s_stb = 1'b0;
  logic [7:0] s_data = 8'h00;
  always @(posedge clk) begin
    s_rst   = rst;
    s_flush = flush;
    s_valid = host_valid;
    s_data  = host_data;
    s_rdy   = tx_ready;
    s_stb   = tx_strobe;
    cyc++;
  end

  logic [7:0] mq[$];
  logic [7:0] rx[$];
  logic       ovf_m  = 1'b0;
  logic [7:0] last_m = 8'h00;

  always @(negedge clk) begin
    if (cyc > 0) begin
      int pre;
      pre = mq.size();
      if (!s_rst) begin
        mq.delete();
        ovf_m  = 1'b0;
        last_m = 8'h00;
        chk("rst_strobe", tx_strobe, 0);
      end else begin
        if (tx_strobe) begin
          chk("strobe_legal", (pre != 0 && s_rdy && !s_flush && !s_stb), 1);
          if (pre != 0) begin
            logic [7:0] b;
            b = mq.pop_front();
            rx.push_back(b);
            last_m = fmt(b);
          end
        end
        if (s_flush) begin
          mq.delete();
          ovf_m = 1'b0;
        end else if (s_valid) begin
          if (pre != DEPTH) mq.push_back(s_data);
          else ovf_m = 1'b1;
        end
      end
      chk("level", fifo_level, mq.size());
      chk("host_ready", host_ready, (mq.size() != DEPTH));
      chk("overflow", overflow, ovf_m);
      chk("tx_data", tx_data, last_m);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    host_valid = v;
    host_data  = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_host_ready", host_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_tx_strobe", tx_strobe, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_data", tx_data, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single byte into an idle path
    drive(1'b1, 8'h41);
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("t2_level_after_write", fifo_level, 1);
    chk("t2_no_early_strobe", tx_strobe, 0);
    @(negedge clk);
    chk("t2_strobe", tx_strobe, 1);
    chk("t2_tx_data", tx_data, EXP_41);
    @(negedge clk);
    chk("t2_strobe_one_cycle", tx_strobe, 0);
    chk("t2_tx_data_hold", tx_data, EXP_41);

    // Fill while the transmitter stays busy, then overrun
    man_rdy = 1'b0;
    man     = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i));
    drive(1'b1, 8'hFF);
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("t3_level_full", fifo_level, 16);
    chk("t3_host_ready_low", host_ready, 0);
    chk("t3_overflow", overflow, 1);

    // Drain through the uart stand-in
    man = 1'b0;
    for (int i = 0; i < 3000 && rx.size() < 17; i++) @(negedge clk);
    chk("t4_drain_count", rx.size(), 17);
    if (rx.size() >= 17)
      for (int i = 0; i < 16; i++) chk("t4_order", rx[1+i], i);
    chk("t4_level_empty", fifo_level, 0);
    chk("t4_overflow_sticky", overflow, 1);
    for (int i = 0; i < 200 && !tx_ready; i++) @(negedge clk);
    chk("t4_uart_idle", tx_ready, 1);
    repeat (3) @(negedge clk);

    // Ready never drops: feeder must still move on to the next byte
    man_rdy = 1'b1;
    man     = 1'b1;
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h56);
    drive(1'b0, 8'h00);
    for (int i = 0; i < 20 && rx.size() < 19; i++) @(negedge clk);
    chk("t6_no_drop_count", rx.size(), 19);
    if (rx.size() >= 19) begin
      chk("t6_byte0", rx[17], 8'h55);
      chk("t6_byte1", rx[18], 8'h56);
    end
    man_rdy = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h60 + i));
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("t6_level_queued", fifo_level, 5);
    chk("t6_overflow_before_flush", overflow, 1);
    @(posedge clk);
    #1;
    flush      = 1'b1;
    host_valid = 1'b1;
    host_data  = 8'h77;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    host_valid = 1'b0;
    @(negedge clk);
    chk("t6_flush_level", fifo_level, 0);
    chk("t6_flush_overflow", overflow, 0);
    chk("t6_flush_host_ready", host_ready, 1);
    repeat (5) @(negedge clk);
    chk("t6_no_strobe_after_flush", rx.size(), 19);

    // Paced instance: three bytes, each later strobe at least GAP_G idle cycles after ready rises
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      g_valid = 1'b1;
      g_data  = 8'(8'h31 + i);
    end
    @(posedge clk);
    #1 g_valid = 1'b0;
    for (int i = 0; i < 800 && g_rx.size() < 3; i++) @(negedge clk);
    chk("t5_gap_count", g_rx.size(), 3);
    if (g_rx.size() >= 3)
      for (int i = 0; i < 3; i++) chk("t5_gap_order", g_rx[i], fmt(8'(8'h31 + i)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
